// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Multi-cycle EX-stage shifter controller. Applies one bit of
//               SLL / SRL / SRA per clock until the latched shift amount is
//               consumed, stalling the pipeline via o_busy meanwhile. A flush
//               (i_kill) aborts any operation in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int N   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [1:0]     i_op,
    input  logic [N-1:0]   i_operand,
    input  logic [SHW-1:0] i_shamt,
    input  logic           i_kill,
    output logic           o_busy,
    output logic           o_done,
    output logic [N-1:0]   o_result
);

    localparam logic [1:0]     c_OP_SRL = 2'b01;
    localparam logic [1:0]     c_OP_SRA = 2'b10;
    localparam logic [SHW-1:0] c_CNT_ONE  = SHW'(1);
    localparam logic [SHW-1:0] c_CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_w;
    logic [SHW-1:0]  r_cnt;
    logic [1:0]      r_op;
    logic            r_busy;
    logic            r_done;

    logic [N-1:0]    w_step;
    logic            w_can_accept;

    // One-bit shift step of the working register; reserved op code acts as SLL
    always_comb begin
        w_step = {r_w[N-2:0], 1'b0};
        case (r_op)
            c_OP_SRL: w_step = {1'b0, r_w[N-1:1]};
            c_OP_SRA: w_step = {r_w[N-1], r_w[N-1:1]};
            default:  w_step = {r_w[N-2:0], 1'b0};
        endcase
    end

    // A new request is only taken when no shift is in flight
    assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);

    // Sequencer FSM; busy/done are registered alongside the state so they
    // always equal a decode of the current state with no input-to-output path
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_w     <= '0;
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_kill) begin
            // Flush: abandon the operation, keep the partial working value
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_w   <= w_step;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_SHIFT;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    if (w_can_accept && i_start) begin
                        r_w   <= i_operand;
                        r_op  <= i_op;
                        r_cnt <= i_shamt;
                        if (i_shamt == c_CNT_ZERO) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_w;

endmodule
`default_nettype wire
